multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback over the shared datapath: register file, ALU, `immgen` and a single memory port. Per state it drives the datapath selects, the immediate-format select and enable for `immgen`, and the memory request handshake. It halts on illegal opcodes.

---
 rtl/multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencing FSM for the RV32I core.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over the shared datapath and
// drives the datapath selects, immgen format/enable and the memory handshake.
// Illegal opcodes park the controller in TRAP until reset.
// Optional feature macro: CTRL_INSTRET_EN builds the retired-instruction
// counter; when it is undefined, instret is tied to zero.
module multicycle_ctrl #(
  parameter int BITS  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BITS-1:0]  instruction,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic [2:0]       state,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             mem_req,
  output logic             mem_we,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [2:0]       imm_fmt,
  output logic             imm_en,
  output logic             retire,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH,
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_FENCE, C_ILLEGAL
  } class_t;

  state_t r_state;
  state_t w_nextState;
  class_t r_class;
  class_t w_decClass;
  logic   w_rdZero;
  logic   w_unusedBits;

  // Map a major opcode onto the instruction class that steers the FSM path.
  function automatic class_t decodeClass(input logic [6:0] op);
    class_t c;
    c = C_ILLEGAL;
    case (op)
      7'b0110011: c = C_OP;
      7'b0010011: c = C_OPIMM;
      7'b0000011: c = C_LOAD;
      7'b0100011: c = C_STORE;
      7'b1100011: c = C_BRANCH;
      7'b0110111: c = C_LUI;
      7'b0010111: c = C_AUIPC;
      7'b1101111: c = C_JAL;
      7'b1100111: c = C_JALR;
      7'b0001111: c = C_FENCE;
      default:    c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  // Immediate format handed to immgen: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J.
  function automatic logic [2:0] immFormat(input class_t c);
    logic [2:0] f;
    f = 3'd0;
    case (c)
      C_OPIMM, C_LOAD, C_JALR, C_FENCE: f = 3'd1;
      C_STORE:                          f = 3'd2;
      C_BRANCH:                         f = 3'd3;
      C_LUI, C_AUIPC:                   f = 3'd4;
      C_JAL:                            f = 3'd5;
      default:                          f = 3'd0;
    endcase
    return f;
  endfunction

  // Compressed encodings (low bits != 11) never match the table, trap them too.
  assign w_decClass   = (instruction[1:0] != 2'b11) ? C_ILLEGAL : decodeClass(instruction[6:0]);
  assign w_rdZero     = (instruction[11:7] == 5'd0);
  assign w_unusedBits = ^instruction[BITS-1:12];

  // State and class registers; class is captured only while decoding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_class <= C_NONE;
    end else begin
      r_state <= w_nextState;
      if (r_state == S_DECODE) begin
        r_class <= w_decClass;
      end
    end
  end

  // Next-state and per-state control outputs; everything forced low in reset.
  always_comb begin
    w_nextState = r_state;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = 2'd0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_write   = 1'b0;
    wb_sel      = 2'd0;
    alu_a_sel   = 1'b0;
    alu_b_sel   = 1'b0;
    imm_fmt     = 3'd0;
    imm_en      = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write    = 1'b1;
          w_nextState = S_DECODE;
        end
      end
      S_DECODE: begin
        imm_en      = 1'b1;
        imm_fmt     = immFormat(w_decClass);
        w_nextState = (w_decClass == C_ILLEGAL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        imm_en    = 1'b1;
        imm_fmt   = immFormat(r_class);
        alu_a_sel = (r_class == C_AUIPC) || (r_class == C_JAL);
        alu_b_sel = !((r_class == C_OP) || (r_class == C_BRANCH));
        case (r_class)
          C_OP, C_OPIMM, C_LUI, C_AUIPC, C_JAL, C_JALR: w_nextState = S_WB;
          C_LOAD, C_STORE: w_nextState = S_MEM;
          C_BRANCH: begin
            pc_write    = 1'b1;
            pc_sel      = branch_taken ? 2'd1 : 2'd0;
            retire      = 1'b1;
            w_nextState = S_FETCH;
          end
          C_FENCE: begin
            pc_write    = 1'b1;
            retire      = 1'b1;
            w_nextState = S_FETCH;
          end
          default: w_nextState = S_TRAP;
        endcase
      end
      S_MEM: begin
        imm_en  = 1'b1;
        imm_fmt = immFormat(r_class);
        mem_req = 1'b1;
        mem_we  = (r_class == C_STORE);
        if (mem_ready) begin
          if (r_class == C_STORE) begin
            pc_write    = 1'b1;
            retire      = 1'b1;
            w_nextState = S_FETCH;
          end else begin
            w_nextState = S_WB;
          end
        end
      end
      S_WB: begin
        imm_en    = 1'b1;
        imm_fmt   = immFormat(r_class);
        reg_write = !w_rdZero;
        pc_write  = 1'b1;
        retire    = 1'b1;
        case (r_class)
          C_LOAD:  wb_sel = 2'd1;
          C_JAL:   begin wb_sel = 2'd2; pc_sel = 2'd1; end
          C_JALR:  begin wb_sel = 2'd2; pc_sel = 2'd2; end
          C_LUI:   wb_sel = 2'd3;
          default: wb_sel = 2'd0;
        endcase
        w_nextState = S_FETCH;
      end
      S_TRAP: begin
        halted = 1'b1;
      end
      default: w_nextState = S_FETCH;
    endcase
    if (!rst_n) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_sel    = 2'd0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      imm_fmt   = 3'd0;
      imm_en    = 1'b0;
      retire    = 1'b0;
      halted    = 1'b0;
    end
  end

  assign state = rst_n ? r_state : 3'd0;

`ifdef CTRL_INSTRET_EN
  logic [CNT_W-1:0] r_instret;

  // Count completed instructions, wrapping naturally at the counter width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign instret = rst_n ? r_instret : '0;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl.
// The stimulus process pushes the hand-computed output vector for every cycle;
// a negedge monitor pops and compares it against the DUT outputs.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [31:0]   instruction;
  logic          mem_ready;
  logic          branch_taken;
  logic [2:0]    state;
  logic          ir_write;
  logic          pc_write;
  logic [1:0]    pc_sel;
  logic          mem_req;
  logic          mem_we;
  logic          reg_write;
  logic [1:0]    wb_sel;
  logic          alu_a_sel;
  logic          alu_b_sel;
  logic [2:0]    imm_fmt;
  logic          imm_en;
  logic          retire;
  logic          halted;
  logic [CW-1:0] instret;

  int          checkCount = 0;
  int          errorCount = 0;
  int          modelCnt   = 0;
  logic [23:0] vecQ[$];
  string       tagQ[$];

  multicycle_ctrl #(.BITS(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .state(state), .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .imm_fmt(imm_fmt),
    .imm_en(imm_en), .retire(retire), .halted(halted), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] packVec(
    input logic [2:0] st, input logic irw, input logic pcw, input logic [1:0] pcs,
    input logic mreq, input logic mwe, input logic rw, input logic [1:0] wbs,
    input logic a, input logic b, input logic [2:0] fmt, input logic ie,
    input logic ret, input logic hlt, input logic [3:0] cnt);
    return {st, irw, pcw, pcs, mreq, mwe, rw, wbs, a, b, fmt, ie, ret, hlt, cnt};
  endfunction

  task automatic checkOutput(input string tag, input logic [23:0] expVec);
    logic [23:0] act;
    act = {state, ir_write, pc_write, pc_sel, mem_req, mem_we, reg_write, wb_sel,
           alu_a_sel, alu_b_sel, imm_fmt, imm_en, retire, halted, instret};
    checkCount++;
    if (act !== expVec) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%h required=%h", tag, act, expVec);
    end
  endtask

  // Monitor: compare one queued expectation per cycle, away from the clock edge.
  always @(negedge clk) begin
    if (vecQ.size() > 0) begin
      checkOutput(tagQ.pop_front(), vecQ.pop_front());
    end
  end

  task automatic applyReset(input string tag);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    branch_taken = 1'b0;
    tagQ.push_back(tag);
    vecQ.push_back(24'h0);
    modelCnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(
    input string tag, input logic mr, input logic bt,
    input logic [2:0] st, input logic irw, input logic pcw, input logic [1:0] pcs,
    input logic mreq, input logic mwe, input logic rw, input logic [1:0] wbs,
    input logic a, input logic b, input logic [2:0] fmt, input logic ie,
    input logic ret, input logic hlt);
    rst_n = 1'b1;
    mem_ready = mr;
    branch_taken = bt;
    tagQ.push_back(tag);
    vecQ.push_back(packVec(st, irw, pcw, pcs, mreq, mwe, rw, wbs, a, b, fmt, ie,
                           ret, hlt, 4'(modelCnt)));
`ifdef CTRL_INSTRET_EN
    if (ret) modelCnt = (modelCnt + 1) % 16;
`endif
    @(posedge clk); #1;
  endtask

  task automatic runAddi(input string tag);
    instruction = 32'h00100093;
    applyStimulus({tag, "_f"}, 1, 0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus({tag, "_d"}, 1, 0, 1, 0,0,0, 0,0,0,0, 0,0, 1,1,0,0);
    applyStimulus({tag, "_e"}, 1, 0, 2, 0,0,0, 0,0,0,0, 0,1, 1,1,0,0);
    applyStimulus({tag, "_w"}, 1, 0, 4, 0,1,0, 0,0,1,0, 0,0, 1,1,1,0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    instruction = 32'h0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk); #1;
    applyReset("reset0");
    applyReset("reset1");

    // ADD x3: F D E W
    instruction = 32'h002081B3;
    applyStimulus("add_fetch",  1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("add_decode", 1,0, 1, 0,0,0, 0,0,0,0, 0,0, 0,1,0,0);
    applyStimulus("add_exec",   1,0, 2, 0,0,0, 0,0,0,0, 0,0, 0,1,0,0);
    applyStimulus("add_wb",     1,0, 4, 0,1,0, 0,0,1,0, 0,0, 0,1,1,0);

    // LW x3 with two memory wait cycles
    instruction = 32'h0000A183;
    applyStimulus("lw_fetch",   1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("lw_decode",  1,0, 1, 0,0,0, 0,0,0,0, 0,0, 1,1,0,0);
    applyStimulus("lw_exec",    1,0, 2, 0,0,0, 0,0,0,0, 0,1, 1,1,0,0);
    applyStimulus("lw_mem_w0",  0,0, 3, 0,0,0, 1,0,0,0, 0,0, 1,1,0,0);
    applyStimulus("lw_mem_w1",  0,0, 3, 0,0,0, 1,0,0,0, 0,0, 1,1,0,0);
    applyStimulus("lw_mem_ok",  1,0, 3, 0,0,0, 1,0,0,0, 0,0, 1,1,0,0);
    applyStimulus("lw_wb",      0,0, 4, 0,1,0, 0,0,1,1, 0,0, 1,1,1,0);

    // SW with one fetch wait cycle
    instruction = 32'h0020A023;
    applyStimulus("sw_fetch_w", 0,0, 0, 0,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("sw_fetch",   1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("sw_decode",  1,0, 1, 0,0,0, 0,0,0,0, 0,0, 2,1,0,0);
    applyStimulus("sw_exec",    1,0, 2, 0,0,0, 0,0,0,0, 0,1, 2,1,0,0);
    applyStimulus("sw_mem",     1,0, 3, 0,1,0, 1,1,0,0, 0,0, 2,1,1,0);

    // BEQ taken then not taken
    instruction = 32'h00208463;
    applyStimulus("beqt_fetch", 1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("beqt_dec",   1,0, 1, 0,0,0, 0,0,0,0, 0,0, 3,1,0,0);
    applyStimulus("beqt_exec",  1,1, 2, 0,1,1, 0,0,0,0, 0,0, 3,1,1,0);
    applyStimulus("beqn_fetch", 1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("beqn_dec",   1,1, 1, 0,0,0, 0,0,0,0, 0,0, 3,1,0,0);
    applyStimulus("beqn_exec",  1,0, 2, 0,1,0, 0,0,0,0, 0,0, 3,1,1,0);

    // JAL x0: rd is zero so no register write
    instruction = 32'h0080006F;
    applyStimulus("jal_fetch",  1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("jal_dec",    1,0, 1, 0,0,0, 0,0,0,0, 0,0, 5,1,0,0);
    applyStimulus("jal_exec",   1,0, 2, 0,0,0, 0,0,0,0, 1,1, 5,1,0,0);
    applyStimulus("jal_wb",     1,0, 4, 0,1,1, 0,0,0,2, 0,0, 5,1,1,0);

    // JALR x1
    instruction = 32'h000080E7;
    applyStimulus("jalr_fetch", 1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("jalr_dec",   1,0, 1, 0,0,0, 0,0,0,0, 0,0, 1,1,0,0);
    applyStimulus("jalr_exec",  1,0, 2, 0,0,0, 0,0,0,0, 0,1, 1,1,0,0);
    applyStimulus("jalr_wb",    1,0, 4, 0,1,2, 0,0,1,2, 0,0, 1,1,1,0);

    // LUI x5
    instruction = 32'h000012B7;
    applyStimulus("lui_fetch",  1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("lui_dec",    1,0, 1, 0,0,0, 0,0,0,0, 0,0, 4,1,0,0);
    applyStimulus("lui_exec",   1,0, 2, 0,0,0, 0,0,0,0, 0,1, 4,1,0,0);
    applyStimulus("lui_wb",     1,0, 4, 0,1,0, 0,0,1,3, 0,0, 4,1,1,0);

    // AUIPC x6
    instruction = 32'h00000317;
    applyStimulus("auipc_fetch",1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("auipc_dec",  1,0, 1, 0,0,0, 0,0,0,0, 0,0, 4,1,0,0);
    applyStimulus("auipc_exec", 1,0, 2, 0,0,0, 0,0,0,0, 1,1, 4,1,0,0);
    applyStimulus("auipc_wb",   1,0, 4, 0,1,0, 0,0,1,0, 0,0, 4,1,1,0);

    // FENCE retires straight from EXEC
    instruction = 32'h0000000F;
    applyStimulus("fence_fetch",1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("fence_dec",  1,0, 1, 0,0,0, 0,0,0,0, 0,0, 1,1,0,0);
    applyStimulus("fence_exec", 1,0, 2, 0,1,0, 0,0,0,0, 0,1, 1,1,1,0);

    // ADDI x0: write-back without register write
    instruction = 32'h00000013;
    applyStimulus("addi0_fetch",1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("addi0_dec",  1,0, 1, 0,0,0, 0,0,0,0, 0,0, 1,1,0,0);
    applyStimulus("addi0_exec", 1,0, 2, 0,0,0, 0,0,0,0, 0,1, 1,1,0,0);
    applyStimulus("addi0_wb",   1,0, 4, 0,1,0, 0,0,0,0, 0,0, 1,1,1,0);

    // ECALL traps and stays halted until reset
    instruction = 32'h00000073;
    applyStimulus("ecall_fetch",1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("ecall_dec",  1,0, 1, 0,0,0, 0,0,0,0, 0,0, 0,1,0,0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus("trap_hold", 1, 1'(i % 2), 7, 0,0,0, 0,0,0,0, 0,0, 0,0,0,1);
    end
    applyReset("trap_reset");

    // Seventeen ADDIs: counter wraps when enabled
    for (int i = 0; i < 17; i++) begin
      runAddi("addi_wrap");
    end

    // LW interrupted by reset while the memory request is held
    instruction = 32'h0000A183;
    applyStimulus("lwr_fetch",  1,0, 0, 1,0,0, 1,0,0,0, 0,0, 0,0,0,0);
    applyStimulus("lwr_dec",    1,0, 1, 0,0,0, 0,0,0,0, 0,0, 1,1,0,0);
    applyStimulus("lwr_exec",   1,0, 2, 0,0,0, 0,0,0,0, 0,1, 1,1,0,0);
    applyStimulus("lwr_mem_w",  0,0, 3, 0,0,0, 1,0,0,0, 0,0, 1,1,0,0);
    applyReset("lwr_reset");

    // Clean restart after the aborted load
    runAddi("addi_post");
    instruction = 32'h002081B3;
    applyStimulus("final_fetch",0,0, 0, 0,0,0, 1,0,0,0, 0,0, 0,0,0,0);

    for (int i = 0; i < 5 && vecQ.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (vecQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL drain: actual=%0d pending required=0", vecQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
